// File: rtl/dmem_line_responder.sv
// Cache-line memory responder: DEPTH x 256-bit lines, one-cycle ack LATENCY cycles after acceptance.
// Optional read/write performance counters are enabled with `DMEM_PERF_CNT_EN.
module dmem_line_responder #(
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 10,
  parameter int unsigned LINE_W  = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0]       rd_cnt_o,
  output logic [31:0]       wr_cnt_o
`endif
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam int unsigned IDX_LSB = 5;
  localparam int unsigned CNT_W   = 8;

  if (LINE_W != 256) begin : g_bad_line_w
    $error("dmem_line_responder: LINE_W must be 256");
  end
  if (LATENCY == 0 || LATENCY > 255) begin : g_bad_latency
    $error("dmem_line_responder: LATENCY must be in 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              accept_c;
  logic [IDX_W-1:0]  idx_c;
  logic [IDX_W-1:0]  idx_sel_c;
  logic              wr_sel_c;
  logic [IDX_W-1:0]  lat_idx;
  logic              lat_write;
  logic [LINE_W-1:0] lat_data;
  logic [LINE_W-1:0] mem [DEPTH];
  logic              unused_addr;

  // Address wraps modulo DEPTH lines; offset and upper bits are don't-care.
  assign idx_c       = addr_i[IDX_LSB +: IDX_W];
  assign unused_addr = ^{addr_i[31:IDX_LSB+IDX_W], addr_i[IDX_LSB-1:0]};

  // Next-state and latency counter.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable_i) begin
          accept_c   = 1'b1;
          cnt_next   = CNT_W'(LATENCY - 1);
          state_next = (LATENCY == 1) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_next = S_ACK;
        end
      end
      S_ACK:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // With LATENCY=1 ACK is entered straight from IDLE, before the request is latched.
  assign idx_sel_c = accept_c ? idx_c   : lat_idx;
  assign wr_sel_c  = accept_c ? write_i : lat_write;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_idx   <= '0;
      lat_write <= 1'b0;
      lat_data  <= '0;
      ack_o     <= 1'b0;
      busy_o    <= 1'b0;
      data_o    <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      ack_o  <= (state_next == S_ACK);
      busy_o <= (state_next != S_IDLE);
      if (accept_c) begin
        lat_idx   <= idx_c;
        lat_write <= write_i;
        lat_data  <= data_i;
      end
      if (state_next == S_ACK && !wr_sel_c) begin
        data_o <= mem[idx_sel_c];
      end
    end
  end

  // Write commits on the edge leaving ACK, so an aborted request never lands.
  always_ff @(posedge clk_i) begin
    if (state == S_ACK && lat_write) begin
      mem[lat_idx] <= lat_data;
    end
  end

`ifdef DMEM_PERF_CNT_EN
  // Saturating completion counters, bumped during the ACK cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_cnt_o <= '0;
      wr_cnt_o <= '0;
    end else if (state == S_ACK) begin
      if (lat_write) begin
        if (wr_cnt_o != 32'hFFFF_FFFF) wr_cnt_o <= wr_cnt_o + 32'd1;
      end else begin
        if (rd_cnt_o != 32'hFFFF_FFFF) rd_cnt_o <= rd_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed bench for dmem_line_responder: LATENCY=10 instance plus a LATENCY=1 back-to-back instance.
// Counter checks are compiled in with `DMEM_PERF_CNT_EN.
module tb_dmem_line_responder;

  localparam int unsigned LAT_A = 10;
  localparam logic [255:0] PRE0 = 256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
  localparam logic [255:0] ECFA = {16{16'hECFA}};
  localparam logic [255:0] Q16  = {8{32'h1600_C0DE}};
  localparam logic [255:0] R32  = {8{32'h3232_A5A5}};
  localparam logic [255:0] S32  = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] W1   = {4{64'h0123_4567_89AB_CDEF}};
  localparam logic [255:0] W2   = {4{64'hFEDC_BA98_7654_3210}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic         a_rst = 1'b1;
  logic [31:0]  a_addr = '0;
  logic [255:0] a_data = '0;
  logic         a_en = 1'b0;
  logic         a_wr = 1'b0;
  logic         a_ack;
  logic [255:0] a_rdata;
  logic         a_busy;

  logic         b_rst = 1'b1;
  logic [31:0]  b_addr = '0;
  logic [255:0] b_data = '0;
  logic         b_en = 1'b0;
  logic         b_wr = 1'b0;
  logic         b_ack;
  logic [255:0] b_rdata;
  logic         b_busy;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] a_rd_cnt, a_wr_cnt, b_rd_cnt, b_wr_cnt;
`endif

  logic         nx_en = 1'b0;
  logic         nx_wr = 1'b0;
  logic [31:0]  nx_addr = '0;
  logic [255:0] nx_data = '0;

  logic         b_wr_t   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [31:0]  b_addr_t [5] = '{32'h0000_0000, 32'h0000_0020, 32'h0000_0040, 32'h0000_0060, 32'h0000_0080};
  logic [255:0] b_data_t [5] = '{256'd0, 256'd0, 256'd0, W1, W2};

  dmem_line_responder #(.DEPTH(512), .LATENCY(LAT_A), .LINE_W(256)) u_dut_a (
    .clk_i    (clk),
    .rst_i    (a_rst),
    .addr_i   (a_addr),
    .data_i   (a_data),
    .enable_i (a_en),
    .write_i  (a_wr),
    .ack_o    (a_ack),
    .data_o   (a_rdata),
    .busy_o   (a_busy)
`ifdef DMEM_PERF_CNT_EN
    ,
    .rd_cnt_o (a_rd_cnt),
    .wr_cnt_o (a_wr_cnt)
`endif
  );

  dmem_line_responder #(.DEPTH(512), .LATENCY(1), .LINE_W(256)) u_dut_b (
    .clk_i    (clk),
    .rst_i    (b_rst),
    .addr_i   (b_addr),
    .data_i   (b_data),
    .enable_i (b_en),
    .write_i  (b_wr),
    .ack_o    (b_ack),
    .data_o   (b_rdata),
    .busy_o   (b_busy)
`ifdef DMEM_PERF_CNT_EN
    ,
    .rd_cnt_o (b_rd_cnt),
    .wr_cnt_o (b_wr_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives a new request on instance A; the current cycle becomes cycle 0.
  task automatic a_req(input logic wr, input logic [31:0] addr, input logic [255:0] data);
    @(negedge clk);
    a_en   = 1'b1;
    a_wr   = wr;
    a_addr = addr;
    a_data = data;
  endtask

  // Watches cycles 0..LAT_A of one transaction; at the ack cycle loads the nx_* request.
  task automatic a_run(input string tag, input logic [255:0] exp_q, input logic drop);
    logic [15:0] ackv;
    logic [15:0] busyv;
    ackv  = '0;
    busyv = '0;
    for (int c = 0; c <= int'(LAT_A); c++) begin
      if (c > 0) @(negedge clk);
      ackv[c]  = a_ack;
      busyv[c] = a_busy;
      if (drop && c == 1) begin
        a_en   = 1'b0;
        a_wr   = 1'b1;
        a_addr = 32'hFFFF_FFE0;
        a_data = '0;
      end
      if (c == int'(LAT_A)) begin
        chk({tag, "_data"}, a_rdata, exp_q);
        a_en   = nx_en;
        a_wr   = nx_wr;
        a_addr = nx_addr;
        a_data = nx_data;
        nx_en  = 1'b0;
      end
    end
    chk({tag, "_ack"},  256'(ackv),  256'(16'h0400));
    chk({tag, "_busy"}, 256'(busyv), 256'(16'h07FE));
  endtask

  initial begin
    logic        any_act;
    logic [15:0] ackv;
    logic [15:0] busyv;

    // Instance A: reset values
    repeat (3) @(negedge clk);
    chk("rst_ack",  256'(a_ack),  256'd0);
    chk("rst_data", a_rdata,      256'd0);
    chk("rst_busy", 256'(a_busy), 256'd0);
    a_rst = 1'b0;

    // Preload line 0, reset (storage survives), then read it back
    a_req(1'b1, 32'h0000_0000, PRE0);
    a_run("wr_pre0", 256'd0, 1'b0);
    @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    a_req(1'b0, 32'h0000_0000, '0);
    a_run("rd_line0", PRE0, 1'b0);

    // Write 0x40 then read it in the cycle right after the ack
    a_req(1'b1, 32'h0000_0040, ECFA);
    nx_en = 1'b1; nx_wr = 1'b0; nx_addr = 32'h0000_0040; nx_data = '0;
    a_run("wr_b2b", PRE0, 1'b0);
    @(negedge clk);
    a_run("rd_b2b", ECFA, 1'b0);

    // Address wrap: 0x4020 aliases line 1
    a_req(1'b1, 32'h0000_4020, 256'd1);
    a_run("wr_wrap", ECFA, 1'b0);
    a_req(1'b0, 32'h0000_0020, '0);
    a_run("rd_wrap", 256'd1, 1'b0);
    a_req(1'b0, 32'h0000_0040, '0);
    a_run("rd_l2_kept", ECFA, 1'b0);

    // Enable dropped after one cycle of a read: still one ack, no second transaction
    a_req(1'b1, 32'h0000_0200, Q16);
    a_run("wr_l16", ECFA, 1'b0);
    a_req(1'b0, 32'h0000_0200, '0);
    a_run("rd_drop", Q16, 1'b1);
    any_act = 1'b0;
    repeat (4) begin
      @(negedge clk);
      any_act = any_act | a_ack | a_busy;
    end
    chk("drop_no_2nd", 256'(any_act), 256'd0);

    // Reset in cycle 5 of a write to 0x400: abort, outputs clear at once, line kept
    a_req(1'b1, 32'h0000_0400, R32);
    a_run("wr_l32", Q16, 1'b0);
    a_req(1'b1, 32'h0000_0400, S32);
    repeat (5) @(negedge clk);
    chk("mid_busy", 256'(a_busy), 256'd1);
    a_rst = 1'b1;
    #1;
    chk("arst_ack",  256'(a_ack),  256'd0);
    chk("arst_busy", 256'(a_busy), 256'd0);
    chk("arst_data", a_rdata,      256'd0);
    a_en = 1'b0;
    @(negedge clk);
    a_rst = 1'b0;
    any_act = 1'b0;
    repeat (12) begin
      @(negedge clk);
      any_act = any_act | a_ack;
    end
    chk("arst_no_ack", 256'(any_act), 256'd0);
    a_req(1'b0, 32'h0000_0400, '0);
    a_run("rd_l32_kept", R32, 1'b0);
`ifdef DMEM_PERF_CNT_EN
    @(negedge clk);
    chk("a_rd_cnt", 256'(a_rd_cnt), 256'd1);
    chk("a_wr_cnt", 256'(a_wr_cnt), 256'd0);
`endif

    // Instance B (LATENCY=1): 3 reads then 2 writes with enable held high
    @(negedge clk);
    b_rst = 1'b0;
`ifdef DMEM_PERF_CNT_EN
    chk("b_rd_cnt_rst", 256'(b_rd_cnt), 256'd0);
    chk("b_wr_cnt_rst", 256'(b_wr_cnt), 256'd0);
`endif
    ackv  = '0;
    busyv = '0;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      ackv[c]  = b_ack;
      busyv[c] = b_busy;
      if (c % 2 == 0 && c < 10) begin
        b_en   = 1'b1;
        b_wr   = b_wr_t[c/2];
        b_addr = b_addr_t[c/2];
        b_data = b_data_t[c/2];
      end else if (c == 10) begin
        b_en = 1'b0;
      end
    end
    chk("b_ack_seq",  256'(ackv),  256'(16'h02AA));
    chk("b_busy_seq", 256'(busyv), 256'(16'h02AA));
`ifdef DMEM_PERF_CNT_EN
    chk("b_rd_cnt", 256'(b_rd_cnt), 256'd3);
    chk("b_wr_cnt", 256'(b_wr_cnt), 256'd2);
`endif

    // Read back both written lines
    @(negedge clk);
    b_en = 1'b1; b_wr = 1'b0; b_addr = 32'h0000_0060;
    @(negedge clk);
    chk("b_rd60_ack",  256'(b_ack), 256'd1);
    chk("b_rd60_data", b_rdata,     W1);
    b_addr = 32'h0000_0080;
    @(negedge clk);
    chk("b_idle_ack", 256'(b_ack), 256'd0);
    @(negedge clk);
    chk("b_rd80_ack",  256'(b_ack), 256'd1);
    chk("b_rd80_data", b_rdata,     W2);
    b_en = 1'b0;
`ifdef DMEM_PERF_CNT_EN
    @(negedge clk);
    chk("b_rd_cnt_end", 256'(b_rd_cnt), 256'd5);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dmem_line_responder.md
Name: dmem_line_responder

Overview:
- Memory-side responder for the 256-bit cache-line request/ack protocol driven by the data-cache controller. The controller holds enable and write with a byte address and a line of write data; this block answers with a one-cycle ack after a fixed latency.
- Holds DEPTH lines of 256-bit storage and replaces the behavioural data memory as a synthesizable, latency-configurable responder at the CPU's memory port.

Parameters:
- DEPTH, 512, number of 256-bit lines; line index = addr_i[13:5] for the default; general form is addr_i[5+$clog2(DEPTH)-1:5].
- LATENCY, 10, cycles from request acceptance to ack; legal range 1..255.
- LINE_W, 256, line width in bits; fixed at 256 and checked by elaboration assert.

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- addr_i  input  32  byte address; bits [4:0] ignored; bits above the index ignored, so the address wraps modulo DEPTH lines.
- data_i  input  256  write line, sampled at acceptance.
- enable_i  input  1  request valid, held by the initiator until ack.
- write_i  input  1  1 = write, 0 = read; sampled at acceptance.
- ack_o  output  1  one-cycle completion pulse.
- data_o  output  256  read line; valid while ack_o=1; holds its value otherwise.
- busy_o  output  1  high in WAIT and ACK.

Behaviour:
- Reset values: ack_o=0, data_o=0, busy_o=0, state=IDLE, counter=0. The storage array is not cleared by reset.
- FSM IDLE:
  - If enable_i=1, accept the request: latch index, write_i and data_i, then load counter = LATENCY-1.
  - Next state is ACK if LATENCY=1, else WAIT.
  - If enable_i=0, stay in IDLE.
- FSM WAIT:
  - Decrement the counter each cycle.
  - When counter==1, go to ACK on the next edge.
  - enable_i, addr_i and data_i are ignored in WAIT. Deasserting enable_i mid-request does not cancel it.
- FSM ACK:
  - ack_o=1 for exactly this cycle.
  - Read: data_o = mem[latched index], registered on entry to ACK.
  - Write: mem[latched index] <= latched data on the edge leaving ACK; data_o is unchanged.
  - Next state is always IDLE.
- Latency: request seen in IDLE at cycle 0 gives ack_o=1 in cycle LATENCY. A read in the cycle right after a write's ack returns the new data.
- Back-to-back requests:
  - The initiator drops enable_i in the cycle after ack.
  - If enable_i is still high in IDLE, a new request is accepted. This is legal and yields a second transaction.
- Reset asserted mid-transaction: abort immediately, write not committed, ack never issued.
- Simultaneous reset and enable: reset wins.
- Parameter LATENCY=0: elaboration error.

Optional Feature:
- Macro name: DMEM_PERF_CNT_EN.
- Defined:
  - Adds ports rd_cnt_o (output, 32) and wr_cnt_o (output, 32).
  - Each counter increments on the ACK cycle of a read or write respectively and saturates at 32'hFFFF_FFFF.
  - Both are cleared by rst_i.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then read line 0 (addr 0x0000, mem[0] preloaded 256'h0000_1111..._FFFF), LATENCY=10 -> ack_o high only in cycle 10, data_o = preload, busy_o high cycles 1-10.
- Write addr 0x0040 with data 256'hECFA repeated, then read 0x0040 in the cycle after ack -> second ack returns 256'hECFA... and mem[2] equals it.
- Address wrap: write 0x4020 (DEPTH=512) with 256'h1 -> mem[1] holds 256'h1; a read of 0x0020 returns 256'h1.
- enable_i dropped after 1 cycle of a read of 0x0200 -> ack_o still pulses in cycle 10 with mem[16]; no second transaction.
- rst_i pulsed in cycle 5 of a write to 0x0400 -> no ack, mem[32] unchanged, all outputs 0 asynchronously.
- LATENCY=1 with DMEM_PERF_CNT_EN: 3 reads then 2 writes back-to-back -> each ack one cycle after acceptance; rd_cnt_o=3, wr_cnt_o=2.
